data_mem_responder: RTL and testbench

//  Memory-side responder for the MEM stage of the 5-stage MIPS pipeline.
//  - Accepts ram_cs/mem_ren/mem_wen requests from the pipeline.
//  - Runs each access against a synchronous single-port SRAM with programmable wait states.
//  - Drives ram_stall back to the pipeline controller, which freezes IF..MEM while it is high.
//  - Request inputs are held stable by the pipeline for as long as ram_stall is high.

---
 rtl/data_mem_responder_pkg.sv | 18 +
 rtl/data_mem_responder_wait_counter.sv | 42 ++++
 rtl/data_mem_responder.sv | 174 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the MEM-stage data memory responder: FSM state
// encodings, latency limits and the wait-counter width.
package data_mem_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int MEM_LAT_MAX = 15;
   localparam int CNT_W       = 4;

   function automatic logic lat_legal(input int lat);
      return (lat >= 1) && (lat <= MEM_LAT_MAX);
   endfunction

endpackage

// File: rtl/data_mem_responder_wait_counter.sv
// Load / decrement down-counter pacing the wait states of one SRAM access;
// last_o marks the final wait cycle (count of one).
module mem_wait_counter
   import data_mem_responder_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         last_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: load wins over decrement, and the counter never wraps below zero.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != {W{1'b0}})) begin
         count_d = count_q - {{(W-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= {W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign last_o = (count_q == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage responder: runs pipeline loads/stores against a synchronous SRAM
// with fixed wait states. Optional one-entry read buffer: DMEM_RD_CACHE_EN.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int READ_LAT  = 3,
   parameter int WRITE_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ram_cs,
   input  logic              mem_ren,
   input  logic              mem_wen,
   input  logic [31:0]       addr,
   input  logic [31:0]       din,
   output logic [31:0]       dout,
   output logic              ram_stall,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_we,
   output logic [31:0]       sram_wdata,
   input  logic [31:0]       sram_rdata
);

   if (!lat_legal(READ_LAT)) begin : g_bad_read_lat
      $error("READ_LAT must lie in 1..15");
   end
   if (!lat_legal(WRITE_LAT)) begin : g_bad_write_lat
      $error("WRITE_LAT must lie in 1..15");
   end

   state_e              state_q;
   state_e              state_d;
   logic [31:0]         dout_q;
   logic                req_s;
   logic [ADDR_W-1:0]   word_s;
   logic [CNT_W-1:0]    lat_s;
   logic                hit_s;
   logic [31:0]         rd_src_s;
   logic                stall_s;
   logic                we_s;
   logic                load_s;
   logic                dec_s;
   logic                last_s;
   logic                dout_load_s;
   logic                unused_addr_bits_s;

   assign req_s      = ram_cs & (mem_ren | mem_wen);
   assign word_s     = addr[ADDR_W+1:2];
   assign lat_s      = mem_wen ? CNT_W'(WRITE_LAT) : CNT_W'(READ_LAT);
   assign sram_addr  = word_s;
   assign sram_wdata = din;
   assign unused_addr_bits_s = ^{addr[31:ADDR_W+2], addr[1:0]};

   mem_wait_counter #(.W(CNT_W)) u_wait_counter (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load_s),
      .load_val_i (lat_s - {{(CNT_W-1){1'b0}}, 1'b1}),
      .dec_i      (dec_s),
      .last_o     (last_s)
   );

   // Access sequencing; the request inputs are held stable while stalled, so the
   // write/read decision is taken straight from mem_wen in every cycle.
   always_comb begin
      state_d     = state_q;
      stall_s     = 1'b0;
      we_s        = 1'b0;
      load_s      = 1'b0;
      dec_s       = 1'b0;
      dout_load_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_s && hit_s) begin
               dout_load_s = 1'b1;
               state_d     = ST_DONE;
            end else if (req_s) begin
               stall_s = 1'b1;
               load_s  = 1'b1;
               if (lat_s == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                  we_s        = mem_wen;
                  dout_load_s = ~mem_wen;
                  state_d     = ST_DONE;
               end else begin
                  state_d = ST_BUSY;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            stall_s = 1'b1;
            dec_s   = 1'b1;
            if (last_s) begin
               we_s        = mem_wen;
               dout_load_s = ~mem_wen;
               state_d     = ST_DONE;
            end else begin
               state_d = ST_BUSY;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (rst) begin
         stall_s = 1'b0;
         we_s    = 1'b0;
      end else begin
         stall_s = stall_s;
      end
   end

   // State and load-data registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         dout_q  <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         if (dout_load_s) begin
            dout_q <= rd_src_s;
         end else begin
            dout_q <= dout_q;
         end
      end
   end

`ifdef DMEM_RD_CACHE_EN
   logic              c_valid_q, c_valid_d;
   logic [ADDR_W-1:0] c_tag_q,   c_tag_d;
   logic [31:0]       c_data_q,  c_data_d;

   assign hit_s    = c_valid_q & (c_tag_q == word_s) & ~mem_wen;
   assign rd_src_s = hit_s ? c_data_q : sram_rdata;

   // Read buffer: refilled by every completed read, kept coherent by stores.
   always_comb begin
      c_valid_d = c_valid_q;
      c_tag_d   = c_tag_q;
      c_data_d  = c_data_q;
      if (dout_load_s) begin
         c_valid_d = 1'b1;
         c_tag_d   = word_s;
         c_data_d  = rd_src_s;
      end else if (we_s && c_valid_q && (c_tag_q == word_s)) begin
         c_data_d = din;
      end else begin
         c_data_d = c_data_q;
      end
   end

   // Read buffer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         c_valid_q <= 1'b0;
         c_tag_q   <= {ADDR_W{1'b0}};
         c_data_q  <= 32'h0000_0000;
      end else begin
         c_valid_q <= c_valid_d;
         c_tag_q   <= c_tag_d;
         c_data_q  <= c_data_d;
      end
   end
`else
   assign hit_s    = 1'b0;
   assign rd_src_s = sram_rdata;
`endif

   assign dout      = dout_q;
   assign ram_stall = stall_s;
   assign sram_we   = we_s;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised scoreboard bench for data_mem_responder against a cycle-level
// reference model of the access protocol and a behavioural SRAM.
module tb_data_mem_responder;

   localparam int ADDR_W    = 10;
   localparam int READ_LAT  = 3;
   localparam int WRITE_LAT = 2;

   logic              clk = 1'b0;
   logic              rst, ram_cs, mem_ren, mem_wen;
   logic [31:0]       addr, din, dout, sram_wdata, sram_rdata;
   logic              ram_stall, sram_we;
   logic [ADDR_W-1:0] sram_addr;

   always #5 clk = ~clk;

   data_mem_responder #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)) dut (
      .clk(clk), .rst(rst), .ram_cs(ram_cs), .mem_ren(mem_ren), .mem_wen(mem_wen),
      .addr(addr), .din(din), .dout(dout), .ram_stall(ram_stall),
      .sram_addr(sram_addr), .sram_we(sram_we), .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata)
   );

   function automatic logic [31:0] init_word(input logic [9:0] w);
      if (w == 10'd5) return 32'hDEADBEEF;
      return {w, 22'h0} ^ 32'h5A5A_1234;
   endfunction

   // Behavioural synchronous SRAM: read data one cycle after the address.
   logic [31:0] sram [0:1023];
   bit          written [0:1023];
   always @(posedge clk) begin
      if (sram_we) begin
         sram[sram_addr]    <= sram_wdata;
         written[sram_addr] <= 1'b1;
      end
      sram_rdata <= written[sram_addr] ? sram[sram_addr] : init_word(sram_addr);
   end

   typedef struct packed {
      logic        stall;
      logic        we;
      logic        chk_dout;
      logic [31:0] dout;
      logic [9:0]  waddr;
      logic [31:0] wdata;
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] ref_mem [0:1023];
   logic [31:0] ref_dout;
`ifdef DMEM_RD_CACHE_EN
   logic        c_valid;
   logic [9:0]  c_tag;
   logic [31:0] c_data;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s @%0t: actual %h required %h", name, $time, act, req);
      end
   endtask

   // Monitor: one expected record per cycle, compared mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("ram_stall", {31'd0, ram_stall}, {31'd0, e.stall});
         check("sram_we", {31'd0, sram_we}, {31'd0, e.we});
         check("sram_addr", {22'd0, sram_addr}, {22'd0, e.waddr});
         if (e.we) check("sram_wdata", sram_wdata, e.wdata);
         if (e.chk_dout) check("dout", dout, e.dout);
      end
   end

   task automatic drive(input logic r, input logic cs, input logic ren, input logic wen,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic e_stall, input logic e_we, input logic e_chk);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; ram_cs = cs; mem_ren = ren; mem_wen = wen; addr = a; din = d;
      e.stall = e_stall; e.we = e_we; e.chk_dout = e_chk; e.dout = ref_dout;
      e.waddr = a[11:2]; e.wdata = d;
      exp_q.push_back(e);
   endtask

   task automatic idle_cycle();
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 0)
         drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, 1'b0, 1'b0, 1'b1);
      else
         drive(1'b0, 1'b1, 1'b0, 1'b0, a, $urandom, 1'b0, 1'b0, 1'b1);
   endtask

   // One complete access as the pipeline sees it: stall cycles, then the DONE cycle.
   task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit both);
      logic [9:0] w;
      int         n;
      bit         hit;
      logic       ren;
      w   = a[11:2];
      n   = wr ? WRITE_LAT : READ_LAT;
      hit = 1'b0;
      ren = wr ? both : 1'b1;
`ifdef DMEM_RD_CACHE_EN
      if (!wr && c_valid && c_tag == w) hit = 1'b1;
`endif
      if (hit) drive(1'b0, 1'b1, ren, wr, a, d, 1'b0, 1'b0, 1'b1);
      else
         for (int k = 0; k < n; k++)
            drive(1'b0, 1'b1, ren, wr, a, d, 1'b1, wr && (k == n - 1), 1'b1);
      if (wr) begin
         ref_mem[w] = d;
`ifdef DMEM_RD_CACHE_EN
         if (c_valid && c_tag == w) c_data = d;
`endif
      end else begin
         ref_dout = ref_mem[w];
`ifdef DMEM_RD_CACHE_EN
         c_valid = 1'b1; c_tag = w; c_data = ref_dout;
`endif
      end
      drive(1'b0, 1'b1, ren, wr, a, d, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic do_reset_cycle(input logic cs, input logic wen, input logic [31:0] a, input logic e_chk);
      drive(1'b1, cs, 1'b0, wen, a, 32'hFFFF_FFFF, 1'b0, 1'b0, e_chk);
      ref_dout = 32'h0;
`ifdef DMEM_RD_CACHE_EN
      c_valid = 1'b0;
`endif
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i[9:0]);
      ref_dout = 32'h0;
`ifdef DMEM_RD_CACHE_EN
      c_valid = 1'b0; c_tag = 10'd0; c_data = 32'h0;
`endif
      rst = 1'b1; ram_cs = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; addr = 32'h0; din = 32'h0;

      do_reset_cycle(1'b0, 1'b0, 32'h0, 1'b0);
      do_reset_cycle(1'b1, 1'b0, 32'h0, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b1);
      idle_cycle();

      access(1'b0, 32'h14, 32'h0, 1'b0);
      idle_cycle();
      access(1'b1, 32'h20, 32'h12345678, 1'b0);
      idle_cycle();
      access(1'b0, 32'h0, 32'h0, 1'b0);
      idle_cycle();
      access(1'b0, 32'h4, 32'h0, 1'b0);
      idle_cycle();
      access(1'b0, 32'h20, 32'h0, 1'b0);
      idle_cycle();

      // Reset in cycle 1 of a write: no strobe, stall drops, memory untouched.
      drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h30, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1);
      do_reset_cycle(1'b1, 1'b1, 32'h30, 1'b1);
      idle_cycle();
      access(1'b0, 32'h30, 32'h0, 1'b0);
      idle_cycle();

      access(1'b1, 32'h40, 32'h0BAD_C0DE, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h44, 32'h1111_2222, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h44, 32'h1111_2222, 1'b0, 1'b0, 1'b1);
      access(1'b0, 32'h40, 32'h0, 1'b0);
      idle_cycle();
      access(1'b0, 32'h44, 32'h0, 1'b0);
      idle_cycle();

`ifdef DMEM_RD_CACHE_EN
      access(1'b0, 32'h14, 32'h0, 1'b0);
      idle_cycle();
      access(1'b0, 32'h14, 32'h0, 1'b0);
      idle_cycle();
      access(1'b1, 32'h14, 32'h1, 1'b0);
      idle_cycle();
      access(1'b0, 32'h14, 32'h0, 1'b0);
      idle_cycle();
`endif

      repeat (150) begin
         logic [31:0] a;
         a       = $urandom;
         a[11:2] = {5'd0, 5'($urandom_range(0, 31))};
         access(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(1, 3)) idle_cycle();
      end

      repeat (4) @(posedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: actual %0d records left required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
